// File: rtl/frame_check_sequence_pkg.sv
// Shared types and constants for the frame check sequence inserter.
// Holds the FSM encoding and a byte-wide reflected CRC-32 step.
package frame_check_sequence_pkg;

    typedef enum logic [1:0] {
        S_PAYLOAD  = 2'd0,
        S_PAD      = 2'd1,
        S_WAIT_FCS = 2'd2,
        S_FCS      = 2'd3
    } fcs_state_e;

    localparam int          FCS_BYTES = 4;
    localparam logic [7:0]  PAD_BYTE  = 8'h00;
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

    // One byte of the LSB-first Ethernet CRC-32 update.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_check_sequence_generator.sv
// CRC-32 generator: accumulates bytes, reports the wire-order FCS
// two cycles after the last byte, then rearms for the next frame.
module frame_check_sequence_generator
    import frame_check_sequence_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  data,
    input  logic        data_enable,
    input  logic        data_last,
    output logic [31:0] checksum,
    output logic        checksum_valid
);

    logic [31:0] crc_q, crc_d;
    logic [31:0] fin_q, fin_d;
    logic [31:0] sum_q, sum_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic [31:0] crc_next;
    logic [31:0] inv;

    // Byte update, final-value capture and byte-swapped result stage.
    always_comb begin
        crc_next = crc32_byte(crc_q, data);
        crc_d    = crc_q;
        fin_d    = fin_q;
        last_d   = data_enable & data_last;
        if (data_enable) begin
            crc_d = data_last ? CRC_INIT : crc_next;
            if (data_last) begin
                fin_d = crc_next;
            end
        end
        inv     = ~fin_q;
        sum_d   = sum_q;
        valid_d = last_q;
        if (last_q) begin
            sum_d = {inv[7:0], inv[15:8], inv[23:16], inv[31:24]};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_q   <= CRC_INIT;
            fin_q   <= '0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            fin_q   <= fin_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign checksum       = sum_q;
    assign checksum_valid = valid_q;

endmodule

// File: rtl/frame_check_sequence_inserter.sv
// Passes payload bytes through, zero-pads short frames, then appends
// the 4-byte CRC-32 FCS and counts completed frames.
module frame_check_sequence_inserter
    import frame_check_sequence_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] frames_sent
);

    localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME_BYTES);
    localparam logic [1:0]  LAST_IDX = 2'(FCS_BYTES - 1);

    fcs_state_e  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  index_q, index_d;
    logic [31:0] fcs_q, fcs_d;
    logic [31:0] frames_q, frames_d;

    logic [16:0] count_inc;
    logic        min_reached;
    logic        xfer;
    logic [31:0] fcs_shift;
    logic        gen_en;
    logic        gen_last;
    logic [31:0] gen_sum;
    logic        gen_valid;

    // Output stage: steer data/valid/ready by state, quiet during reset.
    always_comb begin
        count_inc   = {1'b0, count_q} + 17'd1;
        min_reached = count_inc >= MIN_LEN;
        fcs_shift   = fcs_q << {index_q, 3'b000};
        out_data    = PAD_BYTE;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        in_ready    = 1'b0;
        unique case (state_q)
            S_PAYLOAD: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
            end
            S_PAD: begin
                out_data  = PAD_BYTE;
                out_valid = 1'b1;
            end
            S_WAIT_FCS: begin
                out_valid = 1'b0;
            end
            S_FCS: begin
                out_data  = fcs_shift[31:24];
                out_valid = 1'b1;
                out_last  = index_q == LAST_IDX;
            end
        endcase
        if (!reset_n) begin
            out_valid = 1'b0;
            out_last  = 1'b0;
            in_ready  = 1'b0;
        end
        xfer = out_valid & out_ready;
    end

    // Frame sequencing: byte count, padding, FCS capture and emission.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        fcs_d    = fcs_q;
        frames_d = frames_q;
        gen_en   = 1'b0;
        gen_last = 1'b0;
        unique case (state_q)
            S_PAYLOAD: begin
                if (xfer) begin
                    gen_en  = 1'b1;
                    count_d = (&count_q) ? count_q : count_inc[15:0];
                    if (in_last) begin
                        if (min_reached) begin
                            gen_last = 1'b1;
                            state_d  = S_WAIT_FCS;
                        end else begin
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                if (xfer) begin
                    gen_en  = 1'b1;
                    count_d = (&count_q) ? count_q : count_inc[15:0];
                    if (min_reached) begin
                        gen_last = 1'b1;
                        state_d  = S_WAIT_FCS;
                    end
                end
            end
            S_WAIT_FCS: begin
                if (gen_valid) begin
                    fcs_d   = gen_sum;
                    index_d = 2'd0;
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                if (xfer) begin
                    index_d = index_q + 2'd1;
                    if (index_q == LAST_IDX) begin
                        frames_d = frames_q + 32'd1;
                        count_d  = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_PAYLOAD;
            count_q  <= '0;
            index_q  <= '0;
            fcs_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            index_q  <= index_d;
            fcs_q    <= fcs_d;
            frames_q <= frames_d;
        end
    end

    frame_check_sequence_generator u_gen (
        .clock          (clock),
        .reset_n        (reset_n),
        .data           (out_data),
        .data_enable    (gen_en),
        .data_last      (gen_last),
        .checksum       (gen_sum),
        .checksum_valid (gen_valid)
    );

    assign frames_sent = frames_q;

endmodule
